// File: rtl/score_digit_controller.sv
// score_digit_controller
// Sequences the on-screen BCD counter: a 4-phase inc/clr handshake drives a
// one-digit-per-cycle carry FSM over the working count. Once per frame the count
// is copied into a tear-free display snapshot. From hpos/vpos the snapshot is
// turned into a registered digit code and enable for the seven-segment pipeline.
module score_digit_controller #(
    parameter int NDIGITS   = 4,    // 1..8 BCD digits
    parameter int COL_START = 2,    // first 16-px column tile of the MSD
    parameter int ROW_TILE  = 1,    // 16-px row tile holding the digits
    parameter int V_ACTIVE  = 480,  // first blank line (frame boundary)
    parameter int BLANK_LZ  = 1     // 1: suppress leading zeros
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [9:0]             i_hpos,
    input  logic [9:0]             i_vpos,
    input  logic                   i_display_on,
    input  logic                   i_inc_req,
    input  logic                   i_clr_req,
    output logic                   o_inc_ack,
    output logic [3:0]             o_digit,
    output logic                   o_digit_en,
    output logic                   o_overflow,
    output logic [4*NDIGITS-1:0]   o_value
);

    localparam int VW    = 4 * NDIGITS;
    localparam int PTR_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NDIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CARRY = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [VW-1:0]    r_work;
    logic [VW-1:0]    w_work_nxt;
    logic [VW-1:0]    r_snap;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             r_overflow;
    logic             w_overflow_nxt;
    logic             r_ack;
    logic             r_pending;
    logic [3:0]       w_cur_digit;
    logic             w_frame;
    logic             w_row_hit;
    logic [5:0]       w_tile;
    logic [3:0]       w_digit_nxt;
    logic             w_digit_en_nxt;
    logic [3:0]       r_digit;
    logic             r_digit_en;

    // Digit currently addressed by the carry pointer.
    assign w_cur_digit = r_work[{r_ptr, 2'b00} +: 4];

    // Frame boundary: first pixel of the first blank line.
    assign w_frame = (i_vpos == 10'(V_ACTIVE)) && (i_hpos == 10'd0);

    // Next-state, working count, pointer and overflow for the carry FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        w_state_nxt    = r_state;
        w_work_nxt     = r_work;
        w_ptr_nxt      = r_ptr;
        w_overflow_nxt = r_overflow;
        case (r_state)
            S_IDLE: begin
                if (i_clr_req) begin
                    w_work_nxt     = '0;
                    w_overflow_nxt = 1'b0;
                end else if (i_inc_req) begin
                    w_ptr_nxt   = '0;
                    w_state_nxt = S_CARRY;
                end
            end
            S_CARRY: begin
                if (i_clr_req) begin
                    // Clear aborts the carry; the requester still gets its ack.
                    w_work_nxt     = '0;
                    w_overflow_nxt = 1'b0;
                    w_state_nxt    = S_ACK;
                end else if (w_cur_digit == 4'd9) begin
                    w_work_nxt[{r_ptr, 2'b00} +: 4] = 4'd0;
                    if (r_ptr == LAST_PTR) begin
                        w_overflow_nxt = 1'b1;
                        w_state_nxt    = S_ACK;
                    end else begin
                        w_ptr_nxt = r_ptr + PTR_W'(1);
                    end
                end else begin
                    w_work_nxt[{r_ptr, 2'b00} +: 4] = w_cur_digit + 4'd1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (i_clr_req) begin
                    w_work_nxt     = '0;
                    w_overflow_nxt = 1'b0;
                end
                if (!i_inc_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register plus the datapath it controls; ack is registered.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_work     <= '0;
            r_ptr      <= '0;
            r_overflow <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_work     <= w_work_nxt;
            r_ptr      <= w_ptr_nxt;
            r_overflow <= w_overflow_nxt;
            r_ack      <= (w_state_nxt == S_ACK);
        end
    end

    // Frame snapshot: copy only while idle so a mid-carry value is never shown.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_snap    <= '0;
            r_pending <= 1'b0;
        end else if ((r_state == S_IDLE) && (w_frame || r_pending)) begin
            r_snap    <= r_work;
            r_pending <= 1'b0;
        end else if (w_frame) begin
            r_pending <= 1'b1;
        end
    end

    assign w_tile    = i_hpos[9:4];
    assign w_row_hit = i_display_on && (i_vpos[9:4] == 6'(ROW_TILE));

    // Tile-to-digit decode with leading-zero blanking, MSD leftmost.
    always_comb begin
        logic w_zero_run;
        w_digit_nxt    = 4'd0;
        w_digit_en_nxt = 1'b0;
        w_zero_run     = 1'b1;
        for (int j = NDIGITS - 1; j >= 0; j--) begin
            // True while every digit from the MSD down to j is zero.
            w_zero_run = w_zero_run && (r_snap[4*j +: 4] == 4'd0);
            if (w_row_hit && (w_tile == 6'(COL_START + NDIGITS - 1 - j))) begin
                w_digit_nxt    = r_snap[4*j +: 4];
                w_digit_en_nxt = !((BLANK_LZ != 0) && w_zero_run && (j != 0));
            end
        end
    end

    // One-cycle registered digit output towards the segment decoder.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digit    <= 4'd0;
            r_digit_en <= 1'b0;
        end else begin
            r_digit    <= w_digit_nxt;
            r_digit_en <= w_digit_en_nxt;
        end
    end

    assign o_inc_ack  = r_ack;
    assign o_digit    = r_digit;
    assign o_digit_en = r_digit_en;
    assign o_overflow = r_overflow;
    assign o_value    = r_work;

endmodule

// File: tb/tb_score_digit_controller.sv
// Testbench for score_digit_controller: table-driven reset/handshake vectors,
// directed corner-case sequences and randomized traffic, all checked every cycle
// against an integer-arithmetic reference model of the counter and display.
module tb_score_digit_controller;

    localparam int N    = 4;
    localparam int COL  = 2;
    localparam int ROW  = 1;
    localparam int VACT = 480;
    localparam int BLZ  = 1;

    logic           clk = 1'b0;
    logic           rst, inc, clr, don;
    logic [9:0]     h, v;
    logic           ack, dig_en, ovf;
    logic [3:0]     dig;
    logic [4*N-1:0] val;

    always #5 clk = ~clk;

    score_digit_controller #(
        .NDIGITS(N), .COL_START(COL), .ROW_TILE(ROW), .V_ACTIVE(VACT), .BLANK_LZ(BLZ)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_hpos(h), .i_vpos(v), .i_display_on(don),
        .i_inc_req(inc), .i_clr_req(clr), .o_inc_ack(ack), .o_digit(dig),
        .o_digit_en(dig_en), .o_overflow(ovf), .o_value(val)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*N-1:0] to_bcd(input int x);
        logic [4*N-1:0] r = '0;
        for (int k = 0; k < N; k++) r[4*k +: 4] = 4'((x / pow10(k)) % 10);
        return r;
    endfunction

    // ---------------- reference model (decimal integers) ----------------
    int   m_val = 0, m_snap = 0, m_base = 0, m_k = 0, m_done = 0;
    logic m_ovf = 0, m_carry = 0, m_ack = 0, m_pend = 0;
    logic [3:0] e_digit = 0;
    logic       e_en = 0;

    task automatic model_step();
        int   tile, i, p, t, n_snap;
        logic idle, frame, n_pend;
        if (rst) begin
            e_digit = 0; e_en = 0;
        end else begin
            tile = int'(h) / 16;
            i    = tile - COL;
            if (don && (int'(v) / 16) == ROW && i >= 0 && i < N) begin
                p       = N - 1 - i;
                e_digit = 4'((m_snap / pow10(p)) % 10);
                e_en    = !(BLZ != 0 && m_snap < pow10(p) && p != 0);
            end else begin
                e_digit = 0; e_en = 0;
            end
        end
        idle   = !m_carry && !m_ack;
        frame  = (int'(v) == VACT) && (h == 10'd0);
        n_snap = m_snap;
        n_pend = m_pend;
        if (idle && (frame || m_pend)) begin
            n_snap = m_val; n_pend = 0;
        end else if (frame) begin
            n_pend = 1;
        end
        if (rst) begin
            m_val = 0; m_snap = 0; m_pend = 0; m_ovf = 0; m_carry = 0; m_ack = 0;
            return;
        end
        if (idle) begin
            if (clr) begin
                m_val = 0; m_ovf = 0;
            end else if (inc) begin
                // Digits touched = trailing nines + 1, at most N.
                t = 0;
                while (t < N && ((m_val / pow10(t)) % 10) == 9) t++;
                m_k = (t == N) ? N : t + 1;
                m_base = m_val; m_done = 0; m_carry = 1;
            end
        end else if (m_carry) begin
            if (clr) begin
                m_val = 0; m_ovf = 0; m_carry = 0; m_ack = 1;
            end else begin
                m_done++;
                if (m_done == m_k) begin
                    m_val = (m_base + 1) % pow10(N);
                    if (m_base == pow10(N) - 1) m_ovf = 1;
                    m_carry = 0; m_ack = 1;
                end else begin
                    m_val = m_base - (pow10(m_done) - 1);
                end
            end
        end else begin
            if (clr) begin
                m_val = 0; m_ovf = 0;
            end
            if (!inc) m_ack = 0;
        end
        m_snap = n_snap;
        m_pend = n_pend;
    endtask

    // One clock with the current inputs; outputs compared 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("value", val, to_bcd(m_val));
        check("inc_ack", ack, m_ack);
        check("overflow", ovf, m_ovf);
        check("digit", dig, e_digit);
        check("digit_en", dig_en, e_en);
    endtask

    task automatic do_inc(output int edges);
        inc = 1;
        for (edges = 1; edges <= 20; edges++) begin
            tick();
            if (ack === 1'b1) break;
        end
        if (edges > 20) check("ack_timeout", 0, 1);
        inc = 0;
        tick();
    endtask

    task automatic count_to(input int target);
        int e;
        while (m_val != target) do_inc(e);
    endtask

    task automatic frame_tick();
        h = 10'd0; v = 10'(VACT);
        tick();
        v = 10'd0;
    endtask

    task automatic read_display(output logic [4*N-1:0] digits, output logic [N-1:0] ens);
        v = 10'(ROW * 16 + 3); don = 1;
        for (int i = 0; i < N; i++) begin
            h = 10'((COL + i) * 16 + $urandom_range(0, 15));
            tick();
            digits[4*(N-1-i) +: 4] = dig;
            ens[N-1-i] = dig_en;
        end
        h = 0; v = 0; don = 0;
    endtask

    typedef struct {
        logic       rst, inc, clr;
        logic [9:0] h, v;
        logic       don;
        logic       ack;
        logic [15:0] val;
        logic       ovf;
        logic [3:0] dig;
        logic       en;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit ic, input bit cl, input int hh,
                                input int vv, input bit d, input bit a, input int vl,
                                input bit o, input int dg, input bit e);
        vec_t x;
        x.rst = r; x.inc = ic; x.clr = cl; x.h = 10'(hh); x.v = 10'(vv); x.don = d;
        x.ack = a; x.val = 16'(vl); x.ovf = o; x.dig = 4'(dg); x.en = e;
        return x;
    endfunction

    vec_t tbl [20];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int             e;
        logic [4*N-1:0] dd;
        logic [N-1:0]   ee;

        //             rst inc clr  h   v  don  ack  value   ovf dig en
        tbl[0]  = mk(1, 0, 0,   0,  0, 0,  0, 16'h0000, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0,   0,  0, 0,  0, 16'h0000, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0,   0,  0, 0,  0, 16'h0000, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0,  32, 16, 1,  0, 16'h0000, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0,  48, 20, 1,  0, 16'h0000, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0,  64, 31, 1,  0, 16'h0000, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0,  95, 16, 1,  0, 16'h0000, 0, 0, 1);
        tbl[7]  = mk(0, 0, 0,  96, 16, 1,  0, 16'h0000, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0,  80, 16, 0,  0, 16'h0000, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0,  80, 32, 1,  0, 16'h0000, 0, 0, 0);
        tbl[10] = mk(0, 1, 0,   0,  0, 0,  0, 16'h0000, 0, 0, 0);
        tbl[11] = mk(0, 1, 0,   0,  0, 0,  1, 16'h0001, 0, 0, 0);
        tbl[12] = mk(0, 1, 0,   0,  0, 0,  1, 16'h0001, 0, 0, 0);
        tbl[13] = mk(0, 0, 0,   0,  0, 0,  0, 16'h0001, 0, 0, 0);
        tbl[14] = mk(0, 0, 1,   0,  0, 0,  0, 16'h0000, 0, 0, 0);
        tbl[15] = mk(0, 1, 0,   0,  0, 0,  0, 16'h0000, 0, 0, 0);
        tbl[16] = mk(0, 1, 1,   0,  0, 0,  1, 16'h0000, 0, 0, 0);
        tbl[17] = mk(0, 0, 0,   0,  0, 0,  0, 16'h0000, 0, 0, 0);
        tbl[18] = mk(0, 1, 1,   0,  0, 0,  0, 16'h0000, 0, 0, 0);
        tbl[19] = mk(0, 0, 0,   0,  0, 0,  0, 16'h0000, 0, 0, 0);

        rst = 1; inc = 0; clr = 0; h = 0; v = 0; don = 0;
        #2;

        // Table: reset, idle display, basic handshake and clear priority.
        foreach (tbl[i]) begin
            rst = tbl[i].rst; inc = tbl[i].inc; clr = tbl[i].clr;
            h = tbl[i].h; v = tbl[i].v; don = tbl[i].don;
            tick();
            check($sformatf("row%0d_ack", i), ack, tbl[i].ack);
            check($sformatf("row%0d_value", i), val, tbl[i].val);
            check($sformatf("row%0d_ovf", i), ovf, tbl[i].ovf);
            check($sformatf("row%0d_digit", i), dig, tbl[i].dig);
            check($sformatf("row%0d_en", i), dig_en, tbl[i].en);
        end
        rst = 0; inc = 0; clr = 0;

        // 0009 -> 0010 takes three edges to ack.
        count_to(9);
        do_inc(e);
        check("t2_edges", e, 3);
        check("t2_value", val, 16'h0010);
        check("t2_ack_low", ack, 0);

        // Frame boundary during carry 0099 -> 0100.
        count_to(99);
        frame_tick();
        inc = 1;
        tick();
        h = 0; v = 10'(VACT);
        tick();
        v = 0;
        for (e = 0; e < 20 && ack !== 1'b1; e++) tick();
        check("t5_in_ack", ack, 1);
        read_display(dd, ee);
        check("t5_snap_during", dd, 16'h0099);
        check("t5_en_during", ee, 4'b0011);
        inc = 0;
        tick();
        tick();
        read_display(dd, ee);
        check("t5_snap_after", dd, 16'h0100);
        check("t5_en_after", ee, 4'b0111);
        do_inc(e);
        read_display(dd, ee);
        check("t5_pending_clear", dd, 16'h0100);

        // 9999 wraps in four carry cycles and sets overflow; clear drops it.
        count_to(9999);
        do_inc(e);
        check("t3_edges", e, 5);
        check("t3_value", val, 16'h0000);
        check("t3_ovf", ovf, 1);
        clr = 1;
        tick();
        clr = 0;
        check("t3_ovf_clr", ovf, 0);

        // Snapshot 0042 drawn with leading-zero blanking.
        count_to(42);
        frame_tick();
        read_display(dd, ee);
        check("t6_digits", dd, 16'h0042);
        check("t6_en", ee, 4'b0011);

        // Clear on the second carry cycle from 0999.
        count_to(999);
        inc = 1;
        tick();
        tick();
        check("t4_mid", val, 16'h0990);
        clr = 1;
        tick();
        check("t4_value", val, 16'h0000);
        check("t4_ack", ack, 1);
        check("t4_ovf", ovf, 0);
        clr = 0; inc = 0;
        tick();
        check("t4_ack_low", ack, 0);

        // Reset in the middle of a carry.
        count_to(9);
        inc = 1;
        tick();
        tick();
        rst = 1; inc = 0;
        tick();
        check("rst_mid_value", val, 16'h0000);
        check("rst_mid_ack", ack, 0);
        rst = 0;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst = ($urandom_range(0, 999) == 0);
            clr = ($urandom_range(0, 39) == 0);
            inc = ($urandom_range(0, 3) != 0);
            don = ($urandom_range(0, 7) != 0);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                h = 0; v = 10'(VACT);
            end else if (r == 1) begin
                h = 10'($urandom_range(1, 15)); v = 10'(VACT);
            end else begin
                h = 10'($urandom_range(0, 127)); v = 10'($urandom_range(8, 40));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
